// File: rtl/alu_src_arbiter_if.sv
// Operand-source bus between two requesters, the arbiter and its ALU_2to1 consumer.
// The slave modport is the arbiter side and the master modport is the requester/consumer side.
interface alu_src_arbiter_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  xfer_cnt;

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, sel, out_valid, out_data, xfer_cnt
    );

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, sel, out_valid, out_data, xfer_cnt
    );
endinterface

// File: rtl/alu_src_arbiter.sv
// Two-requester operand arbiter feeding ALU_2to1, with a one-entry output register and a transfer counter.
// Define ARB_FIXED_PRIO_EN to make A win every tie; otherwise ties alternate round-robin.
module alu_src_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_src_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] data_q;
    logic              sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              capture;
    logic              win_b;
    logic              tie_b;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_b = 1'b0;
`else
    // last_gnt_b=1 means B was granted last, so A takes the next tie.
    logic last_gnt_b;

    assign tie_b = ~last_gnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_b <= 1'b1;
        end else if (capture) begin
            last_gnt_b <= win_b;
        end
    end
`endif

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        win_b      = 1'b0;
        bus.gnt_a  = 1'b0;
        bus.gnt_b  = 1'b0;
        if (!rst && (state == IDLE || bus.out_ready)) begin
            if (bus.req_a && bus.req_b) begin
                win_b = tie_b;
            end else begin
                win_b = bus.req_b;
            end
            if (bus.req_a || bus.req_b) begin
                capture    = 1'b1;
                bus.gnt_a  = ~win_b;
                bus.gnt_b  = win_b;
                next_state = BUSY;
            end else begin
                next_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            sel_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                data_q <= win_b ? bus.data_b : bus.data_a;
                sel_q  <= win_b;
            end
            if (state == BUSY && bus.out_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = (state == BUSY);
    assign bus.out_data  = data_q;
    assign bus.sel       = sel_q;
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_alu_src_arbiter.sv
// Directed, table-driven bench for alu_src_arbiter plus a streaming run across the counter wrap.
// Tie expectations follow ARB_FIXED_PRIO_EN when that macro is defined for the build.
module tb_alu_src_arbiter;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam int NVEC   = 21;

    typedef struct {
        logic             rst;
        logic             req_a;
        logic [5:0]       data_a;
        logic             req_b;
        logic [5:0]       data_b;
        logic             out_ready;
        logic             exp_gnt_a;
        logic             exp_gnt_b;
        logic             exp_valid;
        logic [5:0]       exp_data;
        logic             exp_sel;
        logic [7:0]       exp_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    alu_src_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    alu_src_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ra, input int da, input logic rb,
                                input int db, input logic rdy, input logic ga, input logic gb,
                                input logic ov, input int od, input logic s, input int cnt);
        vec_t v;
        v.rst = r;       v.req_a = ra;     v.data_a = 6'(da);
        v.req_b = rb;    v.data_b = 6'(db); v.out_ready = rdy;
        v.exp_gnt_a = ga; v.exp_gnt_b = gb;
        v.exp_valid = ov; v.exp_data = 6'(od); v.exp_sel = s; v.exp_cnt = 8'(cnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst           = v.rst;
        bus.req_a     = v.req_a;
        bus.data_a    = v.data_a;
        bus.req_b     = v.req_b;
        bus.data_b    = v.data_b;
        bus.out_ready = v.out_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic runVector(input int idx, input vec_t v);
        applyStimulus(v);
        #1;
        checkOutput($sformatf("v%0d gnt_a", idx), 32'(bus.gnt_a), 32'(v.exp_gnt_a));
        checkOutput($sformatf("v%0d gnt_b", idx), 32'(bus.gnt_b), 32'(v.exp_gnt_b));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_valid));
        checkOutput($sformatf("v%0d out_data", idx), 32'(bus.out_data), 32'(v.exp_data));
        checkOutput($sformatf("v%0d sel", idx), 32'(bus.sel), 32'(v.exp_sel));
        checkOutput($sformatf("v%0d xfer_cnt", idx), 32'(bus.xfer_cnt), 32'(v.exp_cnt));
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        //               rst ra da rb db rdy  ga gb  ov od sel cnt
        vecs[0]  = mk(1, 1, 5, 1, 2, 1,  0, 0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 5, 0, 0, 1,  1, 0,  1, 5, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1,  0, 0,  0, 5, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1,  0, 0,  0, 5, 0, 1);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1, 1, 2, 1,  1, 0,  1, 1, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
        vecs[6]  = mk(0, 1, 1, 1, 2, 1,  1, 0,  1, 1, 0, 1);
        vecs[7]  = mk(0, 1, 1, 1, 2, 1,  1, 0,  1, 1, 0, 2);
        vecs[8]  = mk(0, 1, 1, 1, 2, 1,  1, 0,  1, 1, 0, 3);
`else
        vecs[6]  = mk(0, 1, 1, 1, 2, 1,  0, 1,  1, 2, 1, 1);
        vecs[7]  = mk(0, 1, 1, 1, 2, 1,  1, 0,  1, 1, 0, 2);
        vecs[8]  = mk(0, 1, 1, 1, 2, 1,  0, 1,  1, 2, 1, 3);
`endif
        vecs[9]  = mk(0, 1, 9, 0, 0, 1,  1, 0,  1, 9, 0, 4);
        vecs[10] = mk(0, 0, 0, 1, 7, 0,  0, 0,  1, 9, 0, 4);
        vecs[11] = mk(0, 0, 0, 1, 7, 0,  0, 0,  1, 9, 0, 4);
        vecs[12] = mk(0, 0, 0, 1, 7, 0,  0, 0,  1, 9, 0, 4);
        vecs[13] = mk(0, 0, 0, 1, 7, 1,  0, 1,  1, 7, 1, 5);
        vecs[14] = mk(1, 0, 0, 1, 7, 1,  0, 0,  0, 0, 0, 0);
        vecs[15] = mk(0, 1, 3, 1, 4, 1,  1, 0,  1, 3, 0, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 1, 33, 1, 0, 1,  1, 33, 1, 0);
        vecs[18] = mk(0, 0, 0, 1, 34, 1, 0, 1,  1, 34, 1, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,  0, 0,  1, 34, 1, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 1,  0, 0,  0, 34, 1, 2);

        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            runVector(i, vecs[i]);
        end

        // Back-to-back stream from A: one capture per cycle and the counter wraps after 256 accepts.
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        for (int i = 0; i <= 257; i++) begin
            v = mk(0, 1, i % 64, 0, 0, 1, 1, 0, 1, i % 64, 0, i % 256);
            applyStimulus(v);
            #1;
            checkOutput($sformatf("stream%0d gnt_a", i), 32'(bus.gnt_a), 32'(v.exp_gnt_a));
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream%0d out_data", i), 32'(bus.out_data), 32'(v.exp_data));
            checkOutput($sformatf("stream%0d xfer_cnt", i), 32'(bus.xfer_cnt), 32'(v.exp_cnt));
            if (i == 0 || i == 255 || i == 256) begin
                checkOutput($sformatf("stream%0d out_valid", i), 32'(bus.out_valid), 32'(v.exp_valid));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
